// File: rtl/mmm_pkg.sv
// Shared types and system constants for the fetch/execute branch path.
package mmm_pkg;

    localparam int XLEN      = 32;
    localparam int OFFSET    = 2;   // log2 of the instruction size in bytes
    localparam int BRQ_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
        logic            btb_hit;
    } branch_info_t;

endpackage

// File: rtl/branch_fifo.sv
// Circular FIFO with an extra pointer bit so full and empty can be told apart.
module branch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic push_i,
    input  logic pop_i,
    input  T     data_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_o  = mem[rd_ptr[AW-1:0]];
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    // Pointer update; clear drops every entry regardless of push/pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/branch_resolver.sv
// Matches execute-stage resolutions against fetch-time predictions and
// drives the BTB update port, the mispredict redirect and the miss counter.
module branch_resolver
    import mmm_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            push_valid_i,
    output logic            push_ready_o,
    input  branch_info_t    push_info_i,
    input  logic            res_valid_i,
    output logic            res_ready_o,
    input  logic            res_taken_i,
    input  logic [XLEN-1:0] res_target_i,
    output logic            btb_valid_o,
    output logic            btb_del_entry_o,
    output logic [XLEN-1:0] btb_res_pc_o,
    output logic [XLEN-1:0] btb_res_target_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [31:0]     mispredict_cnt_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(1) << OFFSET;

    branch_info_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         res_acc;
    logic         miss_taken;
    logic         miss_not_taken;
    logic         mp_acc;
    logic         upd_acc;

    assign push_ready_o = !fifo_full;
    assign res_ready_o  = !fifo_empty;
    assign res_acc      = res_valid_i && !fifo_empty && !flush_i;

    assign miss_taken     = res_taken_i && (!head.pred_taken || (head.pred_target != res_target_i));
    assign miss_not_taken = !res_taken_i && head.pred_taken;
    assign mp_acc         = res_acc && (miss_taken || miss_not_taken);
    // A not-taken branch that still hit in the BTB leaves a stale entry to delete.
    assign upd_acc        = res_acc && (miss_taken || (!res_taken_i && (head.pred_taken || head.btb_hit)));

    branch_fifo #(
        .DEPTH (DEPTH),
        .T     (branch_info_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i || mp_acc),
        .push_i  (push_valid_i),
        .pop_i   (res_acc),
        .data_i  (push_info_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // One-cycle BTB update / redirect pulses plus the saturating miss counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btb_valid_o      <= 1'b0;
            btb_del_entry_o  <= 1'b0;
            btb_res_pc_o     <= '0;
            btb_res_target_o <= '0;
            mispredict_o     <= 1'b0;
            redirect_pc_o    <= '0;
            mispredict_cnt_o <= '0;
        end else begin
            btb_valid_o     <= upd_acc;
            btb_del_entry_o <= upd_acc && !res_taken_i;
            mispredict_o    <= mp_acc;
            if (upd_acc) begin
                btb_res_pc_o     <= head.pc;
                btb_res_target_o <= res_target_i;
            end
            if (mp_acc) begin
                redirect_pc_o <= miss_taken ? res_target_i : head.pc + PC_STEP;
                if (mispredict_cnt_o != '1) mispredict_cnt_o <= mispredict_cnt_o + 1'b1;
            end
        end
    end

endmodule
